// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 scancode-to-ASCII translator:
// scancode constants, prefix FSM states and the output FIFO entry format.
package kbd_pkg;

    // Set-2 scancodes with special meaning to the translator
    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Prefix tracking: which of E0 / F0 have been seen for the current key
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

    // One translated key event as stored in the output FIFO
    typedef struct packed {
        logic [7:0] ascii;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } fifo_entry_t;

    // Keyboard housekeeping bytes (BAT result, echo, ack, errors, resend)
    // that never form part of a key event.
    function automatic logic is_noise(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFC) || (b == 8'hFE);
    endfunction

endpackage

// File: rtl/kbd_keymap.sv
// Combinational set-2 keymap: make code plus modifier state -> ASCII.
// Letters follow shift XOR caps (ctrl turns them into control codes);
// digits and punctuation follow shift only. Unknown codes give 0x00.
module kbd_keymap (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       ctrl,
    output logic [7:0] ascii
);
    import kbd_pkg::*;

    logic [7:0] base;
    logic [7:0] shifted;
    logic       letter;

    // Table lookup followed by modifier selection
    always_comb begin
        base    = 8'h00;
        shifted = 8'h00;
        letter  = 1'b0;
        case (code)
            // letters: lowercase glyph stored, uppercase derived below
            8'h1C: begin base = 8'h61; letter = 1'b1; end // a
            8'h32: begin base = 8'h62; letter = 1'b1; end // b
            8'h21: begin base = 8'h63; letter = 1'b1; end // c
            8'h23: begin base = 8'h64; letter = 1'b1; end // d
            8'h24: begin base = 8'h65; letter = 1'b1; end // e
            8'h2B: begin base = 8'h66; letter = 1'b1; end // f
            8'h34: begin base = 8'h67; letter = 1'b1; end // g
            8'h33: begin base = 8'h68; letter = 1'b1; end // h
            8'h43: begin base = 8'h69; letter = 1'b1; end // i
            8'h3B: begin base = 8'h6A; letter = 1'b1; end // j
            8'h42: begin base = 8'h6B; letter = 1'b1; end // k
            8'h4B: begin base = 8'h6C; letter = 1'b1; end // l
            8'h3A: begin base = 8'h6D; letter = 1'b1; end // m
            8'h31: begin base = 8'h6E; letter = 1'b1; end // n
            8'h44: begin base = 8'h6F; letter = 1'b1; end // o
            8'h4D: begin base = 8'h70; letter = 1'b1; end // p
            8'h15: begin base = 8'h71; letter = 1'b1; end // q
            8'h2D: begin base = 8'h72; letter = 1'b1; end // r
            8'h1B: begin base = 8'h73; letter = 1'b1; end // s
            8'h2C: begin base = 8'h74; letter = 1'b1; end // t
            8'h3C: begin base = 8'h75; letter = 1'b1; end // u
            8'h2A: begin base = 8'h76; letter = 1'b1; end // v
            8'h1D: begin base = 8'h77; letter = 1'b1; end // w
            8'h22: begin base = 8'h78; letter = 1'b1; end // x
            8'h35: begin base = 8'h79; letter = 1'b1; end // y
            8'h1A: begin base = 8'h7A; letter = 1'b1; end // z
            // digit row
            8'h45: begin base = 8'h30; shifted = 8'h29; end // 0 )
            8'h16: begin base = 8'h31; shifted = 8'h21; end // 1 !
            8'h1E: begin base = 8'h32; shifted = 8'h40; end // 2 @
            8'h26: begin base = 8'h33; shifted = 8'h23; end // 3 #
            8'h25: begin base = 8'h34; shifted = 8'h24; end // 4 $
            8'h2E: begin base = 8'h35; shifted = 8'h25; end // 5 %
            8'h36: begin base = 8'h36; shifted = 8'h5E; end // 6 ^
            8'h3D: begin base = 8'h37; shifted = 8'h26; end // 7 &
            8'h3E: begin base = 8'h38; shifted = 8'h2A; end // 8 *
            8'h46: begin base = 8'h39; shifted = 8'h28; end // 9 (
            // punctuation
            8'h0E: begin base = 8'h60; shifted = 8'h7E; end // ` ~
            8'h4E: begin base = 8'h2D; shifted = 8'h5F; end // - _
            8'h55: begin base = 8'h3D; shifted = 8'h2B; end // = +
            8'h54: begin base = 8'h5B; shifted = 8'h7B; end // [ {
            8'h5B: begin base = 8'h5D; shifted = 8'h7D; end // ] }
            8'h5D: begin base = 8'h5C; shifted = 8'h7C; end // \ |
            8'h4C: begin base = 8'h3B; shifted = 8'h3A; end // ; :
            8'h52: begin base = 8'h27; shifted = 8'h22; end // ' "
            8'h41: begin base = 8'h2C; shifted = 8'h3C; end // , <
            8'h49: begin base = 8'h2E; shifted = 8'h3E; end // . >
            8'h4A: begin base = 8'h2F; shifted = 8'h3F; end // / ?
            // whitespace and control keys are shift-insensitive
            8'h29: begin base = 8'h20; shifted = 8'h20; end // space
            8'h5A: begin base = 8'h0D; shifted = 8'h0D; end // enter
            8'h0D: begin base = 8'h09; shifted = 8'h09; end // tab
            8'h66: begin base = 8'h08; shifted = 8'h08; end // backspace
            8'h76: begin base = 8'h1B; shifted = 8'h1B; end // escape
            default: begin base = 8'h00; shifted = 8'h00; end
        endcase

        ascii = base;
        if (letter) begin
            if (ctrl)
                ascii = base - 8'h60;
            else if (shift ^ caps)
                ascii = base - 8'h20;
        end else if (shift) begin
            ascii = shifted;
        end
    end

endmodule

// File: rtl/kbd_ascii_xlate.sv
// PS/2 set-2 scancode stream -> ASCII key events, buffered in a small FIFO.
// A prefix FSM assembles E0/F0 sequences into events, modifier state and a
// held-key map qualify them, and a filter decides which events are queued.
module kbd_ascii_xlate #(
    parameter int unsigned FIFO_DEPTH    = 8,    // power of two, 2..64
    parameter bit          EMIT_BREAK    = 1'b0,
    parameter bit          EMIT_REPEAT   = 1'b1,
    parameter bit          EMIT_NONPRINT = 1'b0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_ascii,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_brk,
    output logic       shift_o,
    output logic       caps_o,
    output logic       ctrl_o,
    output logic       overflow
);
    import kbd_pkg::*;

    localparam int unsigned   ADDR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    prefix_state_t state_reg, state_next;
    logic          ev_valid;
    logic          ev_ext;
    logic          ev_brk;

    // Prefix state register; a reset mid-sequence simply forgets the prefix
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Prefix decoding: a non-prefix byte closes the sequence as one event,
    // housekeeping bytes inside a sequence abandon it
    always_comb begin
        state_next = state_reg;
        ev_valid   = 1'b0;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        if (in_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_data == SC_E0)
                        state_next = ST_EXT;
                    else if (in_data == SC_F0)
                        state_next = ST_BRK;
                    else
                        ev_valid = !is_noise(in_data);
                end
                ST_EXT: begin
                    if (in_data == SC_F0) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        state_next = ST_IDLE;
                        ev_valid   = !is_noise(in_data);
                        ev_ext     = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    ev_valid   = !is_noise(in_data);
                    ev_brk     = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_next = ST_IDLE;
                    ev_valid   = !is_noise(in_data);
                    ev_ext     = 1'b1;
                    ev_brk     = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Modifiers
    // ------------------------------------------------------------------
    logic lshift_reg, lshift_next;
    logic rshift_reg, rshift_next;
    logic ctrl_reg,   ctrl_next;
    logic caps_reg,   caps_next;

    // Modifier tracking; shifts and caps are main-block keys only, while
    // left ctrl (14) and right ctrl (E0 14) share one bit
    always_comb begin
        lshift_next = lshift_reg;
        rshift_next = rshift_reg;
        ctrl_next   = ctrl_reg;
        caps_next   = caps_reg;
        if (ev_valid) begin
            if (!ev_ext && in_data == SC_LSHIFT)
                lshift_next = !ev_brk;
            if (!ev_ext && in_data == SC_RSHIFT)
                rshift_next = !ev_brk;
            if (in_data == SC_CTRL)
                ctrl_next = !ev_brk;
            if (!ev_ext && !ev_brk && in_data == SC_CAPS)
                caps_next = !caps_reg;
        end
    end

    // Modifier state registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lshift_reg <= 1'b0;
            rshift_reg <= 1'b0;
            ctrl_reg   <= 1'b0;
            caps_reg   <= 1'b0;
        end else begin
            lshift_reg <= lshift_next;
            rshift_reg <= rshift_next;
            ctrl_reg   <= ctrl_next;
            caps_reg   <= caps_next;
        end
    end

    assign shift_o = lshift_reg | rshift_reg;
    assign caps_o  = caps_reg;
    assign ctrl_o  = ctrl_reg;

    // ------------------------------------------------------------------
    // Held-key map (non-extended codes only)
    // ------------------------------------------------------------------
    logic [255:0] held_reg, held_next;
    logic         held_we;

    assign held_we = ev_valid && !ev_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_held
            assign held_next[gi] = (held_we && in_data == 8'(gi)) ? !ev_brk : held_reg[gi];
        end
    endgenerate

    // Held-key map register: make sets, break clears
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            held_reg <= '0;
        else
            held_reg <= held_next;
    end

    // ------------------------------------------------------------------
    // Translation and push filter
    // ------------------------------------------------------------------
    logic [7:0]  km_ascii;
    logic [7:0]  ev_ascii;
    logic        ev_repeat;
    logic        push_req;
    fifo_entry_t push_entry;

    kbd_keymap u_keymap (
        .code  (in_data),
        .shift (lshift_reg | rshift_reg),
        .caps  (caps_reg),
        .ctrl  (ctrl_reg),
        .ascii (km_ascii)
    );

    assign ev_ascii  = ev_ext ? 8'h00 : km_ascii;
    assign ev_repeat = !ev_ext && !ev_brk && held_reg[in_data];
    assign push_req  = ev_valid
                     && (!ev_brk    || EMIT_BREAK)
                     && (!ev_repeat || EMIT_REPEAT)
                     && ((ev_ascii != 8'h00) || EMIT_NONPRINT);

    assign push_entry.ascii = ev_ascii;
    assign push_entry.code  = in_data;
    assign push_entry.ext   = ev_ext;
    assign push_entry.brk   = ev_brk;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    fifo_entry_t       mem [FIFO_DEPTH];
    fifo_entry_t       head;
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              full;
    logic              pop;
    logic              push_ok;

    assign out_valid = (count_reg != '0);
    assign full      = (count_reg == DEPTH_CNT);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves the same cycle
    assign push_ok   = push_req && (!full || pop);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Storage array; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_entry;
    end

    // Pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg <= count_next;
            if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Head is shown combinationally and forced to zero when empty
    assign head      = mem[rd_ptr_reg];
    assign out_ascii = out_valid ? head.ascii : 8'h00;
    assign out_code  = out_valid ? head.code  : 8'h00;
    assign out_ext   = out_valid ? head.ext   : 1'b0;
    assign out_brk   = out_valid ? head.brk   : 1'b0;

endmodule

// File: tb/tb_kbd_ascii_xlate.sv
// Bench for kbd_ascii_xlate. Two instances with different filter settings:
//   dut_a: depth 8, breaks dropped, repeats kept, non-printables dropped
//   dut_b: depth 4, breaks dropped, repeats dropped, non-printables kept
// Expected FIFO entries are queued as bytes are driven and compared as the
// DUT pops them.
module tb_kbd_ascii_xlate;
    import kbd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_clrn, a_in_valid, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_ascii, a_out_code;
    logic       a_out_ext, a_out_brk, a_shift, a_caps, a_ctrl, a_ovf;

    logic       b_clrn, b_in_valid, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_ascii, b_out_code;
    logic       b_out_ext, b_out_brk, b_shift, b_caps, b_ctrl, b_ovf;

    kbd_ascii_xlate #(.FIFO_DEPTH(8), .EMIT_BREAK(1'b0), .EMIT_REPEAT(1'b1), .EMIT_NONPRINT(1'b0)) dut_a (
        .clk(clk), .clrn(a_clrn), .in_valid(a_in_valid), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ascii(a_out_ascii),
        .out_code(a_out_code), .out_ext(a_out_ext), .out_brk(a_out_brk),
        .shift_o(a_shift), .caps_o(a_caps), .ctrl_o(a_ctrl), .overflow(a_ovf)
    );

    kbd_ascii_xlate #(.FIFO_DEPTH(4), .EMIT_BREAK(1'b0), .EMIT_REPEAT(1'b0), .EMIT_NONPRINT(1'b1)) dut_b (
        .clk(clk), .clrn(b_clrn), .in_valid(b_in_valid), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ascii(b_out_ascii),
        .out_code(b_out_code), .out_ext(b_out_ext), .out_brk(b_out_brk),
        .shift_o(b_shift), .caps_o(b_caps), .ctrl_o(b_ctrl), .overflow(b_ovf)
    );

    int checks = 0;
    int errors = 0;
    fifo_entry_t q_a[$];
    fifo_entry_t q_b[$];

    typedef struct {
        int               dut;
        int               nbytes;
        logic [7:0][7:0]  bytes;   // first byte in [7]
        int               nexp;
        fifo_entry_t [3:0] exp;    // first entry in [3]
        logic [2:0]       mods;    // {shift, caps, ctrl} after the sequence
    } vec_t;
    vec_t vecs[$];

    function automatic fifo_entry_t ent(input logic [7:0] a, input logic [7:0] c,
                                        input logic x, input logic b);
        return fifo_entry_t'({a, c, x, b});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input int d);
        fifo_entry_t head, e;
        logic        fire;
        if (d == 0) begin
            fire = a_out_valid && a_out_ready;
            head = ent(a_out_ascii, a_out_code, a_out_ext, a_out_brk);
        end else begin
            fire = b_out_valid && b_out_ready;
            head = ent(b_out_ascii, b_out_code, b_out_ext, b_out_brk);
        end
        if (fire) begin
            checks++;
            if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                errors++;
                $display("FAIL pop_dut%0d: got entry %05h, required no entry", d, head);
            end else begin
                e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                if (head !== e) begin
                    errors++;
                    $display("FAIL pop_dut%0d: got entry %05h, required %05h", d, head, e);
                end else begin
                    $display("pop dut%0d ascii=%02h code=%02h ext=%0d brk=%0d",
                             d, head.ascii, head.code, head.ext, head.brk);
                end
            end
        end
    endtask

    // One clock: sample the pop that the coming edge will perform, then
    // return on the next falling edge.
    task automatic step();
        #1;
        pop_check(0);
        pop_check(1);
        @(negedge clk);
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        if (d == 0) begin a_in_valid = 1'b1; a_in_data = b; end
        else        begin b_in_valid = 1'b1; b_in_data = b; end
        step();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input int d, input string name);
        int left;
        for (int i = 0; i < 40; i++) begin
            left = (d == 0) ? q_a.size() + int'(a_out_valid) : q_b.size() + int'(b_out_valid);
            if (left == 0) break;
            step();
        end
        left = (d == 0) ? q_a.size() + int'(a_out_valid) : q_b.size() + int'(b_out_valid);
        chk(name, 32'(left), 0);
        if (d == 0) q_a.delete(); else q_b.delete();
    endtask

    task automatic reset_dut(input int d);
        if (d == 0) a_clrn = 1'b0; else b_clrn = 1'b0;
        step();
        step();
        a_clrn = 1'b1;
        b_clrn = 1'b1;
        step();
    endtask

    task automatic add_vec(input int d, input int nb, input logic [63:0] by,
                           input int ne, input logic [71:0] ex, input logic [2:0] m);
        vec_t v;
        v.dut = d; v.nbytes = nb; v.bytes = by; v.nexp = ne; v.exp = ex; v.mods = m;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        a_clrn = 1'b0; b_clrn = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_in_data = 8'h00; b_in_data = 8'h00;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        step(); step(); step();

        // Reset state, sampled while reset is still asserted
        chk("rst_a_valid", 32'(a_out_valid), 0);
        chk("rst_a_ovf",   32'(a_ovf), 0);
        chk("rst_a_mods",  32'({a_shift, a_caps, a_ctrl}), 0);
        chk("rst_a_head",  32'({a_out_ascii, a_out_code, a_out_ext, a_out_brk}), 0);
        chk("rst_b_valid", 32'(b_out_valid), 0);
        chk("rst_b_ovf",   32'(b_ovf), 0);
        a_clrn = 1'b1; b_clrn = 1'b1;
        step();

        // First make: one entry, visible the cycle after the byte is sampled
        q_a.push_back(ent(8'h61, 8'h1C, 1'b0, 1'b0));
        send_byte(0, 8'h1C);
        chk("latency_a", 32'(a_out_valid), 1);
        chk("latency_head", 32'({a_out_ascii, a_out_code, a_out_ext, a_out_brk}),
            32'(ent(8'h61, 8'h1C, 1'b0, 1'b0)));
        drain(0, "drain_first");

        // dut_a vectors (run back to back, modifier state carries over)
        add_vec(0, 2, 64'hF0_1C_00_00_00_00_00_00, 0, 72'h0, 3'b000);
        add_vec(0, 6, 64'h12_1C_F0_1C_F0_12_00_00, 1, {ent(8'h41, 8'h1C, 0, 0), 54'h0}, 3'b000);
        add_vec(0, 2, 64'h58_1C_00_00_00_00_00_00, 1, {ent(8'h41, 8'h1C, 0, 0), 54'h0}, 3'b010);
        add_vec(0, 2, 64'h12_1C_00_00_00_00_00_00, 1, {ent(8'h61, 8'h1C, 0, 0), 54'h0}, 3'b110);
        add_vec(0, 6, 64'hF0_1C_F0_12_F0_58_00_00, 0, 72'h0, 3'b010);
        add_vec(0, 3, 64'h58_F0_58_00_00_00_00_00, 0, 72'h0, 3'b000);
        add_vec(0, 5, 64'h16_F0_16_12_16_00_00_00, 2,
                {ent(8'h31, 8'h16, 0, 0), ent(8'h21, 8'h16, 0, 0), 36'h0}, 3'b100);
        add_vec(0, 6, 64'hF0_16_F0_12_14_21_00_00, 1, {ent(8'h03, 8'h21, 0, 0), 54'h0}, 3'b001);
        add_vec(0, 7, 64'hF0_21_F0_14_E0_14_1C_00, 1, {ent(8'h01, 8'h1C, 0, 0), 54'h0}, 3'b001);
        add_vec(0, 7, 64'hE0_F0_14_F0_1C_E0_75_00, 0, 72'h0, 3'b000);
        add_vec(0, 7, 64'hE0_AA_1C_F0_1C_AA_29_00, 2,
                {ent(8'h61, 8'h1C, 0, 0), ent(8'h20, 8'h29, 0, 0), 36'h0}, 3'b000);
        add_vec(0, 8, 64'h1C_1C_1C_F0_1C_F0_29_05, 3,
                {ent(8'h61, 8'h1C, 0, 0), ent(8'h61, 8'h1C, 0, 0), ent(8'h61, 8'h1C, 0, 0), 18'h0}, 3'b000);
        add_vec(0, 6, 64'h1C_F0_AA_1C_F0_1C_00_00, 2,
                {ent(8'h61, 8'h1C, 0, 0), ent(8'h61, 8'h1C, 0, 0), 36'h0}, 3'b000);
        // dut_b vectors
        add_vec(1, 2, 64'hE0_75_00_00_00_00_00_00, 1, {ent(8'h00, 8'h75, 1, 0), 54'h0}, 3'b000);
        add_vec(1, 3, 64'hE0_F0_75_00_00_00_00_00, 0, 72'h0, 3'b000);
        add_vec(1, 3, 64'h1C_1C_1C_00_00_00_00_00, 1, {ent(8'h61, 8'h1C, 0, 0), 54'h0}, 3'b000);
        add_vec(1, 3, 64'hF0_1C_12_00_00_00_00_00, 1, {ent(8'h00, 8'h12, 0, 0), 54'h0}, 3'b100);
        add_vec(1, 5, 64'h1C_F0_1C_F0_12_00_00_00, 1, {ent(8'h41, 8'h1C, 0, 0), 54'h0}, 3'b000);
        add_vec(1, 4, 64'h12_12_F0_12_00_00_00_00, 1, {ent(8'h00, 8'h12, 0, 0), 54'h0}, 3'b000);
        add_vec(1, 6, 64'h59_1C_F0_59_F0_1C_00_00, 2,
                {ent(8'h00, 8'h59, 0, 0), ent(8'h41, 8'h1C, 0, 0), 36'h0}, 3'b000);

        foreach (vecs[n]) begin
            v = vecs[n];
            for (int k = 0; k < v.nexp; k++) begin
                if (v.dut == 0) q_a.push_back(v.exp[3-k]);
                else            q_b.push_back(v.exp[3-k]);
            end
            for (int i = 0; i < v.nbytes; i++)
                send_byte(v.dut, v.bytes[7-i]);
            drain(v.dut, $sformatf("vec%0d_count", n));
            if (v.dut == 0) chk($sformatf("vec%0d_mods", n), 32'({a_shift, a_caps, a_ctrl}), 32'(v.mods));
            else            chk($sformatf("vec%0d_mods", n), 32'({b_shift, b_caps, b_ctrl}), 32'(v.mods));
        end

        // Reset between E0 and 75: prefix and modifiers are forgotten
        send_byte(0, 8'h58);
        chk("caps_set", 32'(a_caps), 1);
        send_byte(0, 8'hE0);
        #2 a_clrn = 1'b0;
        #1 chk("async_rst_caps", 32'(a_caps), 0);
        a_clrn = 1'b1;
        @(negedge clk);
        send_byte(0, 8'h75);
        step();
        chk("rst_mid_noentry", 32'(a_out_valid), 0);
        q_a.push_back(ent(8'h61, 8'h1C, 1'b0, 1'b0));
        send_byte(0, 8'h1C);
        drain(0, "rst_mid_after");

        // Overflow on dut_b (depth 4): five makes with the consumer stalled
        reset_dut(1);
        b_out_ready = 1'b0;
        q_b.push_back(ent(8'h71, 8'h15, 0, 0));
        q_b.push_back(ent(8'h77, 8'h1D, 0, 0));
        q_b.push_back(ent(8'h65, 8'h24, 0, 0));
        q_b.push_back(ent(8'h72, 8'h2D, 0, 0));
        send_byte(1, 8'h15);
        send_byte(1, 8'h1D);
        send_byte(1, 8'h24);
        send_byte(1, 8'h2D);
        chk("ovf_not_yet", 32'(b_ovf), 0);
        send_byte(1, 8'h2C);
        chk("ovf_set", 32'(b_ovf), 1);
        chk("ovf_head", 32'({b_out_ascii, b_out_code}), 32'h7115);
        // Push and pop in the same cycle while full
        b_out_ready = 1'b1;
        q_b.push_back(ent(8'h79, 8'h35, 0, 0));
        send_byte(1, 8'h35);
        b_out_ready = 1'b0;
        step();
        chk("full_pushpop_head", 32'({b_out_ascii, b_out_code}), 32'h771D);
        b_out_ready = 1'b1;
        drain(1, "ovf_drain");
        chk("ovf_sticky", 32'(b_ovf), 1);
        chk("empty_head_zero", 32'({b_out_ascii, b_out_code, b_out_ext, b_out_brk}), 0);
        // Pop request on an empty FIFO does nothing
        step();
        chk("empty_pop_ignored", 32'(b_out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
